meas_wr_arbiter: RTL

Parametrised write-path collector between the measurement channels and the register file. It accepts single-cycle result pulses from NUM_CH independent measure channels, buffers each channel in its own FIFO, and issues results one per cycle to the register file write port in round-robin order. It replaces the fixed 5-way one-hot mux, which silently drops results when two channels finish in the same cycle or when a write collides with a register read. Loss is now impossible short of per-channel FIFO overflow, which is flagged.

---
 rtl/meas_wr_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/meas_wr_arbiter.sv
// meas_wr_arbiter: collects single-cycle result pulses from NUM_CH measure
// channels into per-channel FIFOs and forwards them one word per cycle to the
// register-file write port in round-robin order. Drops only on FIFO overflow,
// which raises a sticky per-channel flag.
module meas_wr_arbiter #(
  parameter int NUM_CH     = 5,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            raw_wr_en_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] raw_wr_data_i,
  input  logic                         reg_wr_rdy_i,
  output logic                         reg_wr_en_o,
  output logic [DATA_WIDTH-1:0]        reg_wr_data_o,
  output logic [CH_W-1:0]              reg_wr_ch_o,
  output logic [NUM_CH-1:0]            ovf_o,
  input  logic                         ovf_clr_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Per-channel FIFO status and handshakes.
  logic [NUM_CH-1:0]            not_empty;
  logic [NUM_CH-1:0]            push;
  logic [NUM_CH-1:0]            pop;
  logic [NUM_CH-1:0]            drop;
  logic [NUM_CH*DATA_WIDTH-1:0] head_flat;

  // Arbitration result of the current cycle (stage p0); the output
  // registers form the next stage.
  logic                  grant_vld_p0;
  logic [CH_W-1:0]       grant_ch_p0;
  logic [DATA_WIDTH-1:0] grant_data_p0;

  logic [CH_W-1:0] rr_ptr;

  // Round-robin successor of a granted channel, wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] rr_after(input logic [CH_W-1:0] ch);
    if (ch == CH_W'(NUM_CH - 1)) begin
      return '0;
    end else begin
      return ch + 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------
  // Stage p0 input side: one FIFO per channel
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;

    assign full         = (count == CNT_W'(DEPTH));
    assign not_empty[i] = (count != '0);
    assign pop[i]       = grant_vld_p0 && (grant_ch_p0 == CH_W'(i));
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign push[i]      = raw_wr_en_i[i] && (!full || pop[i]);
    assign drop[i]      = raw_wr_en_i[i] && full && !pop[i];
    assign head_flat[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards all stored words.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push[i], pop[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // Word storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk_i) begin
      if (push[i]) begin
        mem[wr_ptr] <= raw_wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage p0 arbitration: first non-empty channel at or above rr_ptr,
  // otherwise the lowest non-empty channel (wrap-around)
  // ---------------------------------------------------------------------
  logic            hi_found;
  logic            lo_found;
  logic [CH_W-1:0] hi_ch;
  logic [CH_W-1:0] lo_ch;

  // Round-robin search, scanned downward so the lowest match wins.
  always_comb begin
    hi_found     = 1'b0;
    lo_found     = 1'b0;
    hi_ch        = '0;
    lo_ch        = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (not_empty[i]) begin
        lo_found = 1'b1;
        lo_ch    = CH_W'(i);
        if (CH_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_ch    = CH_W'(i);
        end
      end
    end
    grant_vld_p0 = reg_wr_rdy_i && lo_found;
    grant_ch_p0  = hi_found ? hi_ch : lo_ch;
  end

  // Head word of the granted channel.
  always_comb begin
    grant_data_p0 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_ch_p0 == CH_W'(i)) begin
        grant_data_p0 = head_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage p1: registered write port and round-robin pointer
  // ---------------------------------------------------------------------
  // Data and channel hold their last value when no grant is made.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_wr_en_o   <= 1'b0;
      reg_wr_data_o <= '0;
      reg_wr_ch_o   <= '0;
      rr_ptr        <= '0;
    end else begin
      reg_wr_en_o <= grant_vld_p0;
      if (grant_vld_p0) begin
        reg_wr_data_o <= grant_data_p0;
        reg_wr_ch_o   <= grant_ch_p0;
        rr_ptr        <= rr_after(grant_ch_p0);
      end
    end
  end

  // Sticky overflow flags; a drop in the clearing cycle keeps its bit set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_o <= '0;
    end else begin
      ovf_o <= (ovf_clr_i ? '0 : ovf_o) | drop;
    end
  end

endmodule
